// File: rtl/mem_port_if.sv
// mem_port_if: requester, memory and arbiter-status signals of the shared memory port
interface mem_port_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ack;
    logic [DATA_W-1:0] if_rdata;
    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic              dm_ack;
    logic [DATA_W-1:0] dm_rdata;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic [1:0]        owner;

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        input  if_ack, if_rdata, dm_ack, dm_rdata, mem_en, mem_we, mem_addr, mem_wdata, owner
    );

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        output if_ack, if_rdata, dm_ack, dm_rdata, mem_en, mem_we, mem_addr, mem_wdata, owner
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: fixed-latency IF/DM arbiter for one shared memory port with DM priority and IF anti-starvation
module mem_port_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 32,
    parameter int LAT        = 2,
    parameter int STARVE_MAX = 3
) (
    input logic       clk_i,
    input logic       rst_i,
    mem_port_if.slave bus
);
    localparam int CW = LAT > 1 ? $clog2(LAT) : 1;
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_IF   = 2'b01;
    localparam logic [1:0] OWN_DM   = 2'b10;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [SW-1:0]     starve_q, starve_d;
    logic [1:0]        owner_q, owner_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
    logic              if_win;

    // state and datapath registers; reset abandons any in-flight transaction
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            starve_q   <= '0;
            owner_q    <= OWN_NONE;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            starve_q   <= starve_d;
            owner_q    <= owner_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
        end
    end

    // grant decision, access countdown and read-data capture
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        starve_d   = starve_q;
        owner_d    = owner_q;
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;
        if_win     = bus.if_req && (!bus.dm_req || starve_q == SW'(STARVE_MAX));
        unique case (state_q)
            IDLE: begin
                starve_d = (if_win || !bus.if_req) ? '0 :
                           (bus.dm_req && starve_q != SW'(STARVE_MAX)) ? starve_q + 1'b1 : starve_q;
                if (bus.if_req || bus.dm_req) begin
                    state_d = ACCESS;
                    cnt_d   = CW'(LAT - 1);
                    owner_d = if_win ? OWN_IF : OWN_DM;
                    addr_d  = if_win ? bus.if_addr : bus.dm_addr;
                    we_d    = !if_win && bus.dm_we;
                    wdata_d = if_win ? '0 : bus.dm_wdata;
                end
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    state_d    = RESP;
                    if_rdata_d = (owner_q == OWN_IF) ? bus.mem_rdata : if_rdata_q;
                    dm_rdata_d = (owner_q == OWN_DM && !we_q) ? bus.mem_rdata : dm_rdata_q;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
                owner_d = OWN_NONE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.mem_en    = state_q == ACCESS;
    assign bus.mem_we    = state_q == ACCESS && we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.if_ack    = state_q == RESP && owner_q == OWN_IF;
    assign bus.dm_ack    = state_q == RESP && owner_q == OWN_DM;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.dm_rdata  = dm_rdata_q;
    assign bus.owner     = owner_q;
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the processor's single shared memory port between the instruction-fetch requester (IF, read-only) and the data-memory requester (DM, read/write). It sits between the fetch/load-store paths and the unified memory. It runs each access as a fixed-latency transaction and returns data with a one-cycle acknowledge pulse. DM has priority, and a starvation counter guarantees IF forward progress.

## Interface
- ADDR_W, 16, address width
- DATA_W, 32, data width
- LAT, 2, memory access cycles per transaction (≥1)
- STARVE_MAX, 3, consecutive IF losses before IF is forced to win (≥1)

- CLK  in  1  clock, rising edge
- RESET  in  1  asynchronous, active-high reset
- IF_REQ  in  1  IF read request
- IF_ADDR  in  ADDR_W  IF address
- IF_ACK  out  1  one-cycle completion pulse to IF
- IF_RDATA  out  DATA_W  registered IF read data
- DM_REQ  in  1  DM request
- DM_WE  in  1  1 = write, 0 = read
- DM_ADDR  in  ADDR_W  DM address
- DM_WDATA  in  DATA_W  DM write data
- DM_ACK  out  1  one-cycle completion pulse to DM
- DM_RDATA  out  DATA_W  registered DM read data
- MEM_EN  out  1  memory access enable
- MEM_WE  out  1  memory write enable
- MEM_ADDR  out  ADDR_W  memory address
- MEM_WDATA  out  DATA_W  memory write data
- MEM_RDATA  in  DATA_W  memory read data, valid in the last ACCESS cycle
- OWNER  out  2  00 none, 01 IF, 10 DM (current transaction)

## Operation
- FSM states and transitions:
  - IDLE: if any REQ is high, pick the winner, latch addr/we/wdata and owner, set cnt=LAT-1, then go to ACCESS. Otherwise stay in IDLE.
  - ACCESS: drive MEM_* from the latched values. If cnt=0, capture MEM_RDATA and go to RESP. Otherwise decrement cnt.
  - RESP: pulse the owner's ACK, then go to IDLE.
- Winner selection in IDLE:
  - DM_REQ only → DM.
  - IF_REQ only → IF.
  - Both high → DM, unless starve=STARVE_MAX, in which case IF wins.
- starve counter, updated only on IDLE decisions:
  - Increments, saturating at STARVE_MAX, when both REQs are high and DM wins.
  - Clears when IF is granted or when IF_REQ=0 in an IDLE decision.
- Outputs during ACCESS:
  - MEM_EN=1 in every ACCESS cycle and 0 otherwise.
  - MEM_WE=1 only during ACCESS cycles of a DM write.
  - MEM_ADDR/MEM_WDATA hold their latched values for the whole transaction. Requester inputs may change after the grant without effect.
- Read data capture:
  - IF_RDATA updates only on completion of an IF transaction.
  - DM_RDATA updates only on completion of a DM read; a DM write leaves it unchanged.
  - Both hold their values between transactions.
- OWNER: set on the grant, held through ACCESS and RESP, 00 in IDLE.
- REQ/ACK rules:
  - REQ must be held high until ACK.
  - REQ is ignored in ACCESS and RESP.
  - A REQ that is high in IDLE is always a new request. A requester wanting no further access deasserts REQ no later than the edge that ends its ACK cycle. Holding REQ high through ACK gives back-to-back accesses.
- Reset, asynchronous, any state including mid-ACCESS:
  - State → IDLE; all outputs, RDATA registers, cnt and starve → 0.
  - The in-flight transaction is abandoned and no ACK is issued.

## Timing
- A REQ sampled high in IDLE cycle T gives ACCESS in T+1..T+LAT, ACK high in T+LAT+1, and IDLE again in T+LAT+2.
- Request-to-ACK latency is LAT+1 cycles. Peak throughput is one transaction per LAT+2 cycles.
- RDATA is valid in the same cycle as ACK and remains stable afterwards.
- ACK is exactly one cycle wide. IF_ACK and DM_ACK are never high in the same cycle.
- Values after reset: IDLE, every output 0.

## Test plan
(All scenarios use LAT=2, STARVE_MAX=3.)
1. IF read alone: IF_REQ=1, IF_ADDR=0x0010; memory returns 0xA5A50001 in the last ACCESS cycle.
   - MEM_EN high exactly 2 cycles with MEM_ADDR=0x0010 and MEM_WE=0.
   - IF_ACK high 3 cycles after the IDLE sample, with IF_RDATA=0xA5A50001.
   - OWNER=01 during the transaction.
2. DM write: DM_WE=1, DM_ADDR=0x0020, DM_WDATA=0xDEADBEEF.
   - MEM_EN=MEM_WE=1 for 2 cycles with those values.
   - DM_ACK pulses once; DM_RDATA is unchanged (0 after reset).
3. Simultaneous IF and DM reads in the same IDLE cycle:
   - DM served first.
   - IF_ACK exactly 4 cycles after DM_ACK.
   - starve=0 after the IF grant.
4. Starvation: DM_REQ held high continuously and IF_REQ high.
   - DM wins 3 consecutive windows; the 4th window goes to IF (OWNER=01).
   - DM then wins the next window.
5. RESET asserted in the first ACCESS cycle of a DM read.
   - MEM_EN, OWNER and all other outputs drop to 0 asynchronously; no DM_ACK appears.
   - After release, a new IF read completes normally in 3 cycles.
6. IF_REQ held high through ACK with IF_ADDR stepping 0x0000, 0x0004, 0x0008.
   - IF_ACK pulses spaced every 4 cycles.
   - MEM_ADDR matches each latched address.
